// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, default bit period and queue depth,
// and the even-parity helper. Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uartState_t;

    localparam int DEFAULT_DELAY_FRAMES = 286;
    localparam int DEFAULT_FIFO_DEPTH   = 8;

    function automatic logic evenParity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; full/empty/count are registered and the
// pointers wrap naturally because DEPTH is a power of two.
module uart_sync_fifo import uart_pkg::*; #(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W-1:0] rdPtr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   countNext_s;
    logic             full_r;
    logic             empty_r;
    logic             doPush_s;
    logic             doPop_s;

    // A full queue refuses pushes even when a pop happens on the same edge.
    assign doPush_s = push && !full_r;
    assign doPop_s  = pop && !empty_r;

    assign popData = mem_r[rdPtr_r];
    assign full    = full_r;
    assign empty   = empty_r;
    assign count   = count_r;

    // Occupancy update: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        countNext_s = count_r;
        case ({doPush_s, doPop_s})
            2'b10:   countNext_s = count_r + (PTR_W+1)'(1'b1);
            2'b01:   countNext_s = count_r - (PTR_W+1)'(1'b1);
            default: countNext_s = count_r;
        endcase
    end

    // Pointers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_r <= {PTR_W{1'b0}};
            rdPtr_r <= {PTR_W{1'b0}};
            count_r <= {(PTR_W+1){1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (doPush_s) begin
                wrPtr_r <= wrPtr_r + PTR_W'(1'b1);
            end
            if (doPop_s) begin
                rdPtr_r <= rdPtr_r + PTR_W'(1'b1);
            end
            count_r <= countNext_s;
            full_r  <= (countNext_s == (PTR_W+1)'(DEPTH));
            empty_r <= (countNext_s == {(PTR_W+1){1'b0}});
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (doPush_s) begin
            mem_r[wrPtr_r] <= pushData;
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Queued 8N1 UART transmitter. Define UART_TX_QUEUE_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit.
module uart_tx_queue import uart_pkg::*; #(
    parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(DELAY_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_FRAMES - 1);

    uartState_t       state_r;
    uartState_t       stateNext_s;
    logic [CNT_W-1:0] bitCnt_r;
    logic [CNT_W-1:0] bitCntNext_s;
    logic [2:0]       bitIdx_r;
    logic [2:0]       bitIdxNext_s;
    logic [7:0]       shift_r;
    logic [7:0]       shiftNext_s;
    logic             txLine_r;
    logic             txNext_s;
    logic             busy_r;
    logic             notEmpty_r;
    logic             bitDone_s;
    logic             fifoPop_s;
    logic             fifoFull_s;
    logic             fifoEmpty_s;
    logic [7:0]       fifoData_s;
`ifdef UART_TX_QUEUE_PARITY_EN
    logic             parity_r;
    logic             parityNext_s;
`endif

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (tx_valid),
        .pushData (tx_data),
        .pop      (fifoPop_s),
        .popData  (fifoData_s),
        .full     (fifoFull_s),
        .empty    (fifoEmpty_s),
        .count    (fifo_count)
    );

    assign tx_ready  = !fifoFull_s;
    assign uart_tx   = txLine_r;
    assign busy      = busy_r;
    assign bitDone_s = (bitCnt_r == CNT_LAST);

    // Next-state logic; a new byte is loaded from IDLE or straight out of STOP.
    always_comb begin
        stateNext_s  = state_r;
        bitCntNext_s = bitCnt_r;
        bitIdxNext_s = bitIdx_r;
        shiftNext_s  = shift_r;
        txNext_s     = txLine_r;
        fifoPop_s    = 1'b0;
`ifdef UART_TX_QUEUE_PARITY_EN
        parityNext_s = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                bitCntNext_s = CNT_ZERO;
                bitIdxNext_s = 3'd0;
                if (notEmpty_r) begin
                    fifoPop_s   = 1'b1;
                    shiftNext_s = fifoData_s;
                    stateNext_s = ST_START;
                    txNext_s    = 1'b0;
`ifdef UART_TX_QUEUE_PARITY_EN
                    parityNext_s = evenParity(fifoData_s);
`endif
                end else begin
                    txNext_s = 1'b1;
                end
            end
            ST_START: begin
                if (bitDone_s) begin
                    bitCntNext_s = CNT_ZERO;
                    bitIdxNext_s = 3'd0;
                    stateNext_s  = ST_DATA;
                    txNext_s     = shift_r[0];
                end else begin
                    bitCntNext_s = bitCnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (bitDone_s) begin
                    bitCntNext_s = CNT_ZERO;
                    if (bitIdx_r == 3'd7) begin
                        bitIdxNext_s = 3'd0;
`ifdef UART_TX_QUEUE_PARITY_EN
                        stateNext_s = ST_PARITY;
                        txNext_s    = parity_r;
`else
                        stateNext_s = ST_STOP;
                        txNext_s    = 1'b1;
`endif
                    end else begin
                        bitIdxNext_s = bitIdx_r + 3'd1;
                        shiftNext_s  = {1'b0, shift_r[7:1]};
                        txNext_s     = shift_r[1];
                    end
                end else begin
                    bitCntNext_s = bitCnt_r + CNT_ONE;
                end
            end
`ifdef UART_TX_QUEUE_PARITY_EN
            ST_PARITY: begin
                if (bitDone_s) begin
                    bitCntNext_s = CNT_ZERO;
                    stateNext_s  = ST_STOP;
                    txNext_s     = 1'b1;
                end else begin
                    bitCntNext_s = bitCnt_r + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (bitDone_s) begin
                    bitCntNext_s = CNT_ZERO;
                    bitIdxNext_s = 3'd0;
                    // Chain straight into the next start bit so bursts have no idle gap.
                    if (notEmpty_r) begin
                        fifoPop_s   = 1'b1;
                        shiftNext_s = fifoData_s;
                        stateNext_s = ST_START;
                        txNext_s    = 1'b0;
`ifdef UART_TX_QUEUE_PARITY_EN
                        parityNext_s = evenParity(fifoData_s);
`endif
                    end else begin
                        stateNext_s = ST_IDLE;
                        txNext_s    = 1'b1;
                    end
                end else begin
                    bitCntNext_s = bitCnt_r + CNT_ONE;
                end
            end
            default: begin
                stateNext_s  = ST_IDLE;
                bitCntNext_s = CNT_ZERO;
                bitIdxNext_s = 3'd0;
                txNext_s     = 1'b1;
            end
        endcase
    end

    // Serializer registers; the line and busy flag are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            bitCnt_r   <= CNT_ZERO;
            bitIdx_r   <= 3'd0;
            shift_r    <= 8'h00;
            txLine_r   <= 1'b1;
            busy_r     <= 1'b0;
            notEmpty_r <= 1'b0;
        end else begin
            state_r    <= stateNext_s;
            bitCnt_r   <= bitCntNext_s;
            bitIdx_r   <= bitIdxNext_s;
            shift_r    <= shiftNext_s;
            txLine_r   <= txNext_s;
            busy_r     <= (stateNext_s != ST_IDLE);
            notEmpty_r <= !fifoEmpty_s;
        end
    end

`ifdef UART_TX_QUEUE_PARITY_EN
    // Parity of the byte in flight, captured when it is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= parityNext_s;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: expected bytes are queued at push time and a
// line monitor checks every cycle of each frame against them.
`timescale 1ns/1ps
module tb_uart_tx_queue;

    localparam int D  = 4;
    localparam int D2 = 2;
`ifdef UART_TX_QUEUE_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_LEN = FRAME_BITS * D;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_tx;
    logic       busy;
    logic [3:0] fifo_count;
    logic [7:0] txData2;
    logic       txValid2;
    logic       txReady2;
    logic       uartTx2;
    logic       busy2;
    logic [3:0] fifoCount2;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [7:0] expQ[$];
    logic [7:0] expQ2[$];

    uart_tx_queue #(.DELAY_FRAMES(D), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .uart_tx(uart_tx), .busy(busy), .fifo_count(fifo_count)
    );

    uart_tx_queue #(.DELAY_FRAMES(D2), .FIFO_DEPTH(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(txData2), .tx_valid(txValid2),
        .tx_ready(txReady2), .uart_tx(uartTx2), .busy(busy2), .fifo_count(fifoCount2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line level for frame bit idx of byte b: start, 8 data LSB first, [parity], stop.
    function automatic logic frameBit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else if (idx == 9 && FRAME_BITS == 11) return ^b;
        else return 1'b1;
    endfunction

    // ---------------- line monitor for the DELAY_FRAMES=4 instance ----------------
    logic        monInFrame = 1'b0;
    logic        monSpurious;
    logic        monBad;
    logic [7:0]  monByte;
    logic [10:0] monObs;
    logic [10:0] monExp;
    int monK, monBadK;
    int monStartCnt = 0;
    int framesDone = 0;
    int firstStartCyc = 0, lastStartCyc = 0, lastEndCyc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            monInFrame = 1'b0;
        end else begin
            if (!monInFrame && uart_tx === 1'b0) begin
                monSpurious = (expQ.size() == 0);
                if (monSpurious) begin
                    vectors++;
                    errors++;
                    monByte = 8'h00;
                    $display("FAIL unexpected_start: line went low at cycle %0d with nothing queued, required idle high", cyc);
                end else begin
                    monByte = expQ.pop_front();
                end
                monExp = 11'h7FF;
                for (int i = 0; i < FRAME_BITS; i++) monExp[i] = frameBit(monByte, i);
                monObs = 11'h7FF;
                monInFrame = 1'b1;
                monK = 0;
                monBad = 1'b0;
                monBadK = -1;
                lastStartCyc = cyc;
                if (monStartCnt == 0) firstStartCyc = cyc;
                monStartCnt++;
            end
            if (monInFrame) begin
                if (uart_tx !== frameBit(monByte, monK / D)) begin
                    if (!monBad) monBadK = monK;
                    monBad = 1'b1;
                end
                if ((monK % D) == (D / 2)) monObs[monK / D] = uart_tx;
                monK++;
                if (monK == FRAME_LEN) begin
                    monInFrame = 1'b0;
                    lastEndCyc = cyc + 1;
                    framesDone++;
                    if (!monSpurious) begin
                        vectors++;
                        if (monBad) begin
                            errors++;
                            $display("FAIL frame_bits byte %h: observed bits %b, required %b (first bad cycle %0d)",
                                     monByte, monObs, monExp, monBadK);
                        end
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    int  badFullCnt = 0;
    logic sawFull = 1'b0;

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, output int acceptCyc);
        int waitCnt;
        waitCnt = 0;
        acceptCyc = 0;
        tx_data = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && waitCnt < 2000) begin
            sawFull = 1'b1;
            if (fifo_count !== 4'd8) badFullCnt++;
            tick();
            waitCnt++;
        end
        if (tx_ready !== 1'b1) begin
            vectors++;
            errors++;
            $display("FAIL push_timeout: tx_ready=%b, required 1", tx_ready);
        end else begin
            @(posedge clk);
            expQ.push_back(b);
            tick();
            acceptCyc = cyc;
        end
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (monStartCnt == 0 && n < budget) begin
            tick();
            n++;
        end
        if (monStartCnt == 0) begin
            vectors++;
            errors++;
            $display("FAIL start_timeout: no start bit within %0d cycles, required one", budget);
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (framesDone < target && n < budget) begin
            tick();
            n++;
        end
        if (framesDone < target) begin
            vectors++;
            errors++;
            $display("FAIL frame_timeout: %0d frames done, required %0d", framesDone, target);
        end
    endtask

    task automatic wait_until_cyc(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 5000) begin
            tick();
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int lows;
        rst_n = 1'b0;
        repeat (3) tick();
        vectors++; if (uart_tx !== 1'b1)    begin errors++; $display("FAIL reset_uart_tx: got %b, required 1", uart_tx); end
        vectors++; if (tx_ready !== 1'b1)   begin errors++; $display("FAIL reset_tx_ready: got %b, required 1", tx_ready); end
        vectors++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        vectors++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d, required 0", fifo_count); end
        rst_n = 1'b1;
        lows = 0;
        repeat (100) begin
            tick();
            if (uart_tx !== 1'b1) lows++;
        end
        vectors++; if (lows != 0) begin errors++; $display("FAIL idle_after_reset: %0d low cycles, required 0", lows); end
    endtask

    task automatic test_single_byte;
        int acc;
        int target;
        monStartCnt = 0;
        target = framesDone + 1;
        push_byte(8'h4C, acc);
        tx_valid = 1'b0;
        wait_start(20);
        vectors++;
        if (firstStartCyc - acc != 2) begin
            errors++;
            $display("FAIL start_latency: start bit %0d cycles after accept, required 2", firstStartCyc - acc);
        end
        wait_until_cyc(firstStartCyc + FRAME_LEN - 1);
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_last_cycle: got %b, required 1", busy); end
        tick();
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_frame: got %b, required 0", busy); end
        wait_frames(target, FRAME_LEN + 20);
    endtask

    task automatic test_burst;
        logic [7:0] msg [12];
        int acc;
        int target;
        msg = '{8'h4C, 8'h75, 8'h73, 8'h68, 8'h61, 8'h79, 8'h20, 8'h4C, 8'h61, 8'h62, 8'h73, 8'h20};
        monStartCnt = 0;
        sawFull = 1'b0;
        badFullCnt = 0;
        target = framesDone + 12;
        for (int i = 0; i < 12; i++) push_byte(msg[i], acc);
        tx_valid = 1'b0;
        vectors++;
        if (!sawFull || badFullCnt != 0) begin
            errors++;
            $display("FAIL backpressure: ready-low seen=%b with %0d cycles not at count 8, required 1 and 0", sawFull, badFullCnt);
        end
        wait_frames(target, 12 * FRAME_LEN + 100);
        vectors++;
        if (lastEndCyc - firstStartCyc != 12 * FRAME_LEN) begin
            errors++;
            $display("FAIL burst_span: line active %0d cycles, required %0d", lastEndCyc - firstStartCyc, 12 * FRAME_LEN);
        end
        vectors++; if (expQ.size() != 0) begin errors++; $display("FAIL burst_leftover: %0d bytes unsent, required 0", expQ.size()); end
    endtask

    task automatic test_reset_mid_frame;
        int acc;
        int lows;
        monStartCnt = 0;
        push_byte(8'hA5, acc);
        push_byte(8'h11, acc);
        push_byte(8'h22, acc);
        push_byte(8'h33, acc);
        tx_valid = 1'b0;
        wait_start(20);
        wait_until_cyc(firstStartCyc + 4 * D + 1);
        rst_n = 1'b0;
        #1;
        vectors++; if (uart_tx !== 1'b1)    begin errors++; $display("FAIL midreset_uart_tx: got %b, required 1", uart_tx); end
        vectors++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL midreset_fifo_count: got %0d, required 0", fifo_count); end
        vectors++; if (busy !== 1'b0)       begin errors++; $display("FAIL midreset_busy: got %b, required 0", busy); end
        expQ.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        lows = 0;
        repeat (100) begin
            tick();
            if (uart_tx !== 1'b1) lows++;
        end
        vectors++; if (lows != 0) begin errors++; $display("FAIL residual_bits: %0d low cycles after release, required 0", lows); end
    endtask

`ifdef UART_TX_QUEUE_PARITY_EN
    task automatic test_parity;
        logic [7:0] bytes [2];
        logic       pbit [2];
        int acc;
        bytes = '{8'h07, 8'h03};
        pbit  = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            monStartCnt = 0;
            push_byte(bytes[i], acc);
            tx_valid = 1'b0;
            wait_start(20);
            wait_until_cyc(firstStartCyc + 9 * D + 1);
            vectors++;
            if (uart_tx !== pbit[i]) begin
                errors++;
                $display("FAIL parity_bit byte %h: got %b, required %b", bytes[i], uart_tx, pbit[i]);
            end
            wait_frames(framesDone + 1, FRAME_LEN + 20);
            vectors++;
            if (lastEndCyc - firstStartCyc != 11 * D) begin
                errors++;
                $display("FAIL parity_frame_len: got %0d cycles, required %0d", lastEndCyc - firstStartCyc, 11 * D);
            end
        end
    endtask
`endif

    task automatic test_min_bit;
        logic [7:0] b;
        logic       bad;
        int n;
        tick();
        txData2 = 8'hFF;
        txValid2 = 1'b1;
        @(posedge clk);
        expQ2.push_back(8'hFF);
        tick();
        txData2 = 8'h00;
        @(posedge clk);
        expQ2.push_back(8'h00);
        tick();
        txValid2 = 1'b0;
        n = 0;
        while (uartTx2 !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        for (int f = 0; f < 2; f++) begin
            b = (expQ2.size() != 0) ? expQ2.pop_front() : 8'h5A;
            bad = 1'b0;
            for (int k = 0; k < FRAME_BITS * D2; k++) begin
                if (uartTx2 !== frameBit(b, k / D2)) bad = 1'b1;
                tick();
            end
            vectors++;
            if (bad) begin
                errors++;
                $display("FAIL min_bit_frame byte %h: line differs from required %0d-cycle waveform", b, FRAME_BITS * D2);
            end
        end
        vectors++; if (busy2 !== 1'b0)  begin errors++; $display("FAIL min_bit_busy: got %b, required 0", busy2); end
        vectors++; if (uartTx2 !== 1'b1) begin errors++; $display("FAIL min_bit_idle: got %b, required 1", uartTx2); end
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        txValid2 = 1'b0;
        txData2  = 8'h00;
        test_reset();
        test_single_byte();
        test_burst();
        test_reset_mid_frame();
`ifdef UART_TX_QUEUE_PARITY_EN
        test_parity();
`endif
        test_min_bit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DELAY_FRAMES, default 286, meaning clock cycles per UART bit period; legal values are at least 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of queued bytes; legal values are powers of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port tx_data, input, 8 bits, the byte to transmit.
REQ-006 SHALL have port tx_valid, input, 1 bit: tx_data is valid this cycle.
REQ-007 SHALL have port tx_ready, output, 1 bit: the queue can accept a byte; it equals !full.
REQ-008 SHALL have port uart_tx, output, 1 bit, the serial line; idles high.
REQ-009 SHALL have port busy, output, 1 bit: the serializer is not in IDLE.
REQ-010 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits, the number of queued bytes.

Function
REQ-011 SHALL accept a byte only on an edge where tx_valid && tx_ready; when tx_valid is high and tx_ready is low, tx_data is ignored and the upstream holds it.
REQ-012 SHALL base tx_ready on registered full only; when full, a push is refused even if a pop occurs in the same cycle.
REQ-013 SHALL decide a pop from the registered not-empty flag only; there is no FIFO bypass.
REQ-014 SHALL update fifo_count by +1 on push-only, -1 on pop-only, and leave it unchanged on simultaneous push and pop.
REQ-015 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-016 SHALL implement serializer states IDLE, START, DATA, PARITY (only when compiled in), and STOP.
REQ-017 SHALL, in IDLE with the FIFO not empty, pop one byte into a shift register and enter START on the next edge.
REQ-018 SHALL hold each bit for exactly DELAY_FRAMES cycles, counted 0..DELAY_FRAMES-1 by a $clog2(DELAY_FRAMES)-bit counter that clears on every bit transition.
REQ-019 SHALL drive uart_tx = 0 in START, data bits LSB first in DATA (8 bits, tracked by a 3-bit index), and 1 in STOP.
REQ-020 SHALL register uart_tx so it changes in the same cycle the state changes.
REQ-021 SHALL make the start bit begin (uart_tx falling) 2 cycles after the accepting edge when the block is idle with an empty FIFO.
REQ-022 SHALL, at the end of STOP, pop and go directly to START if the FIFO is not empty, giving back-to-back frames with zero idle cycles; otherwise it goes to IDLE.
REQ-023 SHALL produce a frame length of exactly 10*DELAY_FRAMES cycles (11*DELAY_FRAMES with parity).

Reset
REQ-024 SHALL, while rst_n is low, force uart_tx=1, busy=0, tx_ready=1, fifo_count=0, state IDLE, all counters 0, and FIFO pointers 0, regardless of clk.
REQ-025 SHALL, on reset during any frame, truncate the frame immediately, discard queued bytes, and emit no residual bits after release.

Configuration
REQ-026 SHALL, with UART_TX_QUEUE_PARITY_EN defined, insert a PARITY state between DATA and STOP that drives even parity (XOR of the 8 data bits) for DELAY_FRAMES cycles.
REQ-027 SHALL, without UART_TX_QUEUE_PARITY_EN, go directly from DATA to STOP and contain no parity logic.

Structure
REQ-028 SHALL take the serializer state encoding, the default DELAY_FRAMES (286), and the default FIFO_DEPTH (8) from shared package uart_pkg, which the receiver also uses.
REQ-029 SHALL place the storage in sub-module uart_sync_fifo, a single-clock FIFO with push/pop/full/empty/count ports; the serializer stays in uart_tx_queue.

Verification (bench uses DELAY_FRAMES=4 unless stated otherwise)
REQ-030 SHALL cover reset: apply rst_n low -> uart_tx=1, tx_ready=1, busy=0, fifo_count=0; uart_tx stays high for 100 cycles after release with no push.
REQ-031 SHALL cover a single byte: push 0x4C -> uart_tx falls 2 cycles later, emits bits 0,0,0,1,1,0,0,1,0,1 at 4 cycles each, then busy=0 after 40 cycles.
REQ-032 SHALL cover a burst: push "Lushay Labs " (12 bytes) with tx_valid held high -> tx_ready drops while fifo_count=8, all 12 bytes appear in order with no gap, and the line is active for exactly 480 cycles.
REQ-033 SHALL cover reset mid-frame: assert rst_n low during data bit 3 of 0xA5 with 3 bytes queued -> uart_tx=1 asynchronously, fifo_count=0, and no transmission after release.
REQ-034 SHALL cover parity: with UART_TX_QUEUE_PARITY_EN defined, push 0x07 -> parity bit 1 and frame length 44 cycles; push 0x03 -> parity bit 0.
REQ-035 SHALL cover the minimum bit time: with DELAY_FRAMES=2, push 0xFF then 0x00 -> two back-to-back 20-cycle frames with bit-exact timing.
